// File: rtl/cg_seq_pkg.sv
// cg_seq_pkg: shared types and reset values for the clock-gating wake
// sequencer.
//   dom_state_t : per-domain ICG state (GATED, WAKING, ACTIVE)
//   seq_state_t : wake sequencer state (SEQ_IDLE, SEQ_GRANT, SEQ_SETTLE)
//   *_RESET     : values the state and output registers take under aresetn
package cg_seq_pkg;

  typedef enum logic [1:0] {
    GATED  = 2'd0,
    WAKING = 2'd1,
    ACTIVE = 2'd2
  } dom_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_GRANT  = 2'd1,
    SEQ_SETTLE = 2'd2
  } seq_state_t;

  localparam dom_state_t DOM_RESET_STATE     = GATED;
  localparam seq_state_t SEQ_RESET_STATE     = SEQ_IDLE;
  localparam logic       DOMAIN_CLK_EN_RESET = 1'b0;

endpackage

// File: rtl/arbiter_round_robin.sv
// arbiter_round_robin: combinational round-robin pick.
//   req   [NUM_REQ]   : requesting indices
//   ptr   [PTR_WIDTH] : index with highest priority this cycle (< NUM_REQ)
//   grant [NUM_REQ]   : one-hot, first requester at or after ptr (wrapping);
//                       all-zero when nothing requests
module arbiter_round_robin
  import cg_seq_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [PTR_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant
);

  logic                 found;
  logic [PTR_WIDTH-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_WIDTH'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cg_wake_sequencer.sv
// cg_wake_sequencer: drives the ICG enables of NUM_DOMAINS gated clock
// domains. Idle domains gate after a shared countdown; wake requests are
// granted round-robin, one domain per sequence, with a programmable settle
// time after each ungate.
//   clk_in             : free-running clock
//   aresetn            : asynchronous active-low reset
//   cfg_cg_enable      : 1 = gating active, 0 = every domain forced running
//   cfg_cg_idle_count  : idle countdown reload value
//   cfg_stagger_cycles : settle cycles after each ungate
//   wake_req, busy     : per-domain wake request / activity
//   domain_clk_en      : registered ICG enables
//   wake_ack           : domain ACTIVE
//   domain_gated       : domain GATED
//   seq_busy           : sequencer not idle
module cg_wake_sequencer
  import cg_seq_pkg::*;
#(
  parameter int NUM_DOMAINS     = 4,
  parameter int IDLE_CNTR_WIDTH = 4,
  parameter int STAGGER_WIDTH   = 3
) (
  input  logic                       clk_in,
  input  logic                       aresetn,
  input  logic                       cfg_cg_enable,
  input  logic [IDLE_CNTR_WIDTH-1:0] cfg_cg_idle_count,
  input  logic [STAGGER_WIDTH-1:0]   cfg_stagger_cycles,
  input  logic [NUM_DOMAINS-1:0]     wake_req,
  input  logic [NUM_DOMAINS-1:0]     busy,
  output logic [NUM_DOMAINS-1:0]     domain_clk_en,
  output logic [NUM_DOMAINS-1:0]     wake_ack,
  output logic [NUM_DOMAINS-1:0]     domain_gated,
  output logic                       seq_busy
);

  localparam int PTR_W = $clog2(NUM_DOMAINS);

  seq_state_t                 seq_state, seq_next;
  logic [PTR_W-1:0]           rr_ptr, rr_ptr_next;
  logic [STAGGER_WIDTH-1:0]   settle_cnt, settle_cnt_next;
  logic [NUM_DOMAINS-1:0]     sel, sel_next;

  logic [NUM_DOMAINS-1:0]     gated_vec;
  logic [NUM_DOMAINS-1:0]     wake_pending;
  logic [NUM_DOMAINS-1:0]     arb_grant;
  logic [NUM_DOMAINS-1:0]     grant_wake;
  logic [NUM_DOMAINS-1:0]     settle_done;

  assign wake_pending = wake_req & gated_vec;
  assign seq_busy     = (seq_state != SEQ_IDLE);

  arbiter_round_robin #(
    .NUM_REQ   (NUM_DOMAINS),
    .PTR_WIDTH (PTR_W)
  ) u_arb (
    .req   (wake_pending),
    .ptr   (rr_ptr),
    .grant (arb_grant)
  );

  // ---------------- sequencer ----------------
  always_ff @(posedge clk_in or negedge aresetn) begin
    if (!aresetn) begin
      seq_state  <= SEQ_RESET_STATE;
      rr_ptr     <= '0;
      settle_cnt <= '0;
      sel        <= '0;
    end else begin
      seq_state  <= seq_next;
      rr_ptr     <= rr_ptr_next;
      settle_cnt <= settle_cnt_next;
      sel        <= sel_next;
    end
  end

  always_comb begin
    seq_next        = seq_state;
    rr_ptr_next     = rr_ptr;
    settle_cnt_next = settle_cnt;
    sel_next        = sel;
    grant_wake      = '0;
    settle_done     = '0;
    if (!cfg_cg_enable) begin
      // Every domain is forced ACTIVE, so any sequence in flight is moot.
      seq_next = SEQ_IDLE;
      sel_next = '0;
    end else begin
      case (seq_state)
        SEQ_IDLE: begin
          if (|wake_pending) seq_next = SEQ_GRANT;
        end
        SEQ_GRANT: begin
          if (|arb_grant) begin
            grant_wake      = arb_grant;
            sel_next        = arb_grant;
            settle_cnt_next = cfg_stagger_cycles;
            seq_next        = SEQ_SETTLE;
            for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
              if (arb_grant[PTR_W'(k)]) rr_ptr_next = PTR_W'((k + 1) % NUM_DOMAINS);
            end
          end else begin
            seq_next = SEQ_IDLE;
          end
        end
        SEQ_SETTLE: begin
          if (settle_cnt == '0) begin
            settle_done = sel;
            sel_next    = '0;
            seq_next    = SEQ_IDLE;
          end else begin
            settle_cnt_next = settle_cnt - STAGGER_WIDTH'(1);
          end
        end
        default: seq_next = SEQ_IDLE;
      endcase
    end
  end

  // ---------------- per-domain FSMs ----------------
  for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
    dom_state_t                 st, st_next;
    logic [IDLE_CNTR_WIDTH-1:0] cnt, cnt_next;
    logic                       clk_en_q;

    always_ff @(posedge clk_in or negedge aresetn) begin
      if (!aresetn) begin
        st       <= DOM_RESET_STATE;
        cnt      <= '0;
        clk_en_q <= DOMAIN_CLK_EN_RESET;
      end else begin
        st       <= st_next;
        cnt      <= cnt_next;
        // Registered from next state so the enable flips together with it.
        clk_en_q <= (st_next != GATED);
      end
    end

    always_comb begin
      st_next  = st;
      cnt_next = cnt;
      if (!cfg_cg_enable) begin
        st_next  = ACTIVE;
        cnt_next = cfg_cg_idle_count;
      end else begin
        case (st)
          GATED: begin
            if (grant_wake[d]) st_next = WAKING;
          end
          WAKING: begin
            if (settle_done[d]) begin
              st_next  = ACTIVE;
              cnt_next = cfg_cg_idle_count;
            end
          end
          ACTIVE: begin
            if (wake_req[d] || busy[d]) cnt_next = cfg_cg_idle_count;
            else if (cnt != '0)         cnt_next = cnt - IDLE_CNTR_WIDTH'(1);
            else                        st_next  = GATED;
          end
          default: st_next = GATED;
        endcase
      end
    end

    assign gated_vec[d]     = (st == GATED);
    assign domain_gated[d]  = (st == GATED);
    assign wake_ack[d]      = (st == ACTIVE);
    assign domain_clk_en[d] = clk_en_q;
  end

endmodule

// File: tb/tb_cg_wake_sequencer.sv
module tb_cg_wake_sequencer;

  logic       clk_in = 1'b0;
  logic       aresetn = 1'b0;
  logic       cfg_cg_enable = 1'b1;
  logic [3:0] cfg_cg_idle_count = '0;
  logic [2:0] cfg_stagger_cycles = '0;
  logic [3:0] wake_req = '0;
  logic [3:0] busy = '0;
  logic [3:0] domain_clk_en, wake_ack, domain_gated;
  logic       seq_busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  cg_wake_sequencer #(
    .NUM_DOMAINS     (4),
    .IDLE_CNTR_WIDTH (4),
    .STAGGER_WIDTH   (3)
  ) dut (
    .clk_in             (clk_in),
    .aresetn            (aresetn),
    .cfg_cg_enable      (cfg_cg_enable),
    .cfg_cg_idle_count  (cfg_cg_idle_count),
    .cfg_stagger_cycles (cfg_stagger_cycles),
    .wake_req           (wake_req),
    .busy               (busy),
    .domain_clk_en      (domain_clk_en),
    .wake_ack           (wake_ack),
    .domain_gated       (domain_gated),
    .seq_busy           (seq_busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0] clk_en;
    logic [3:0] ack;
    logic [3:0] gated;
    logic       sbusy;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  bsy;
    logic        en;
    logic [3:0]  idle;
    logic [2:0]  stag;
    int unsigned edges;
    logic [3:0]  c;
    logic [3:0]  a;
    logic [3:0]  g;
    logic        s;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [3:0] req, logic [3:0] bsy, logic en,
                              logic [3:0] idle, logic [2:0] stag, int unsigned edges,
                              logic [3:0] c, logic [3:0] a, logic [3:0] g, logic s);
    vec_t v;
    v.rst = rst; v.req = req; v.bsy = bsy; v.en = en; v.idle = idle; v.stag = stag;
    v.edges = edges; v.c = c; v.a = a; v.g = g; v.s = s;
    return v;
  endfunction

  task automatic drive(input logic [3:0] req, input logic [3:0] bsy, input logic en,
                       input logic [3:0] idle, input logic [2:0] stag);
    wake_req           = req;
    busy               = bsy;
    cfg_cg_enable      = en;
    cfg_cg_idle_count  = idle;
    cfg_stagger_cycles = stag;
  endtask

  task automatic do_reset();
    drive(4'h0, 4'h0, 1'b1, 4'h0, 3'h0);
    aresetn = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    aresetn = 1'b1;
  endtask

  task automatic push_exp(input logic [3:0] c, input logic [3:0] a, input logic [3:0] g,
                          input logic s);
    exp_t e;
    e.clk_en = c; e.ack = a; e.gated = g; e.sbusy = s;
    sb_q.push_back(e);
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      if (domain_clk_en !== e.clk_en || wake_ack !== e.ack ||
          domain_gated !== e.gated || seq_busy !== e.sbusy) begin
        n_fail++;
        $display("FAIL %s: got clk_en=%b ack=%b gated=%b seq_busy=%b, expected clk_en=%b ack=%b gated=%b seq_busy=%b",
                 name, domain_clk_en, wake_ack, domain_gated, seq_busy,
                 e.clk_en, e.ack, e.gated, e.sbusy);
      end
    end
  endtask

  // Expect (c,a,g,s) after `edges` rising edges, sampled on the falling edge.
  task automatic run(input int unsigned edges, input logic [3:0] c, input logic [3:0] a,
                     input logic [3:0] g, input logic s, input string name);
    push_exp(c, a, g, s);
    repeat (edges) @(posedge clk_in);
    @(negedge clk_in);
    check_pop(name);
  endtask

  task automatic check_now(input logic [3:0] c, input logic [3:0] a, input logic [3:0] g,
                           input logic s, input string name);
    push_exp(c, a, g, s);
    check_pop(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_now(4'h0, 4'h0, 4'hF, 1'b0, "reset_values");

    // Single wake: stagger 2, idle 3
    tbl.push_back(mk(1, 4'b0000, 4'h0, 1, 4'd3, 3'd2, 2, 4'b0000, 4'b0000, 4'b1111, 0));
    tbl.push_back(mk(0, 4'b0010, 4'h0, 1, 4'd3, 3'd2, 1, 4'b0000, 4'b0000, 4'b1111, 1));
    tbl.push_back(mk(0, 4'b0010, 4'h0, 1, 4'd3, 3'd2, 1, 4'b0010, 4'b0000, 4'b1101, 1));
    tbl.push_back(mk(0, 4'b0010, 4'h0, 1, 4'd3, 3'd2, 2, 4'b0010, 4'b0000, 4'b1101, 1));
    tbl.push_back(mk(0, 4'b0010, 4'h0, 1, 4'd3, 3'd2, 1, 4'b0010, 4'b0010, 4'b1101, 0));
    tbl.push_back(mk(0, 4'b0010, 4'h0, 1, 4'd3, 3'd2, 5, 4'b0010, 4'b0010, 4'b1101, 0));
    tbl.push_back(mk(0, 4'b0000, 4'h0, 1, 4'd3, 3'd2, 3, 4'b0010, 4'b0010, 4'b1101, 0));
    tbl.push_back(mk(0, 4'b0000, 4'h0, 1, 4'd3, 3'd2, 1, 4'b0000, 4'b0000, 4'b1111, 0));
    // Simultaneous wake 1011: order 0, 1, 3, enables 4 cycles apart
    tbl.push_back(mk(1, 4'b1011, 4'h0, 1, 4'd3, 3'd1, 1, 4'b0000, 4'b0000, 4'b1111, 1));
    tbl.push_back(mk(0, 4'b1011, 4'h0, 1, 4'd3, 3'd1, 1, 4'b0001, 4'b0000, 4'b1110, 1));
    tbl.push_back(mk(0, 4'b1011, 4'h0, 1, 4'd3, 3'd1, 2, 4'b0001, 4'b0001, 4'b1110, 0));
    tbl.push_back(mk(0, 4'b1011, 4'h0, 1, 4'd3, 3'd1, 1, 4'b0001, 4'b0001, 4'b1110, 1));
    tbl.push_back(mk(0, 4'b1011, 4'h0, 1, 4'd3, 3'd1, 1, 4'b0011, 4'b0001, 4'b1100, 1));
    tbl.push_back(mk(0, 4'b1011, 4'h0, 1, 4'd3, 3'd1, 2, 4'b0011, 4'b0011, 4'b1100, 0));
    tbl.push_back(mk(0, 4'b1011, 4'h0, 1, 4'd3, 3'd1, 1, 4'b0011, 4'b0011, 4'b1100, 1));
    tbl.push_back(mk(0, 4'b1011, 4'h0, 1, 4'd3, 3'd1, 1, 4'b1011, 4'b0011, 4'b0100, 1));
    tbl.push_back(mk(0, 4'b1011, 4'h0, 1, 4'd3, 3'd1, 2, 4'b1011, 4'b1011, 4'b0100, 0));
    tbl.push_back(mk(0, 4'b1011, 4'h0, 1, 4'd3, 3'd1, 2, 4'b1011, 4'b1011, 4'b0100, 0));
    // Zero settings: idle 0, stagger 0
    tbl.push_back(mk(1, 4'b0100, 4'h0, 1, 4'd0, 3'd0, 1, 4'b0000, 4'b0000, 4'b1111, 1));
    tbl.push_back(mk(0, 4'b0100, 4'h0, 1, 4'd0, 3'd0, 1, 4'b0100, 4'b0000, 4'b1011, 1));
    tbl.push_back(mk(0, 4'b0100, 4'h0, 1, 4'd0, 3'd0, 1, 4'b0100, 4'b0100, 4'b1011, 0));
    tbl.push_back(mk(0, 4'b0100, 4'h4, 1, 4'd0, 3'd0, 2, 4'b0100, 4'b0100, 4'b1011, 0));
    tbl.push_back(mk(0, 4'b0000, 4'h4, 1, 4'd0, 3'd0, 3, 4'b0100, 4'b0100, 4'b1011, 0));
    tbl.push_back(mk(0, 4'b0000, 4'h0, 1, 4'd0, 3'd0, 1, 4'b0000, 4'b0000, 4'b1111, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].req, tbl[i].bsy, tbl[i].en, tbl[i].idle, tbl[i].stag);
      run(tbl[i].edges, tbl[i].c, tbl[i].a, tbl[i].g, tbl[i].s, $sformatf("vec%0d", i));
    end

    // busy hold-off: idle 5, busy[2] toggling every 4 cycles never lets it gate
    do_reset();
    drive(4'b0100, 4'h0, 1, 4'd5, 3'd0);
    run(3, 4'b0100, 4'b0100, 4'b1011, 0, "busyoff_wake");
    for (int k = 0; k < 4; k++) begin
      drive(4'b0000, 4'b0100, 1, 4'd5, 3'd0);
      run(4, 4'b0100, 4'b0100, 4'b1011, 0, $sformatf("busyoff_hi%0d", k));
      drive(4'b0000, 4'b0000, 1, 4'd5, 3'd0);
      run(4, 4'b0100, 4'b0100, 4'b1011, 0, $sformatf("busyoff_lo%0d", k));
    end
    drive(4'b0000, 4'b0100, 1, 4'd5, 3'd0);
    run(1, 4'b0100, 4'b0100, 4'b1011, 0, "busyoff_reload");
    drive(4'b0000, 4'b0000, 1, 4'd5, 3'd0);
    run(5, 4'b0100, 4'b0100, 4'b1011, 0, "busyoff_low5");
    run(1, 4'b0000, 4'b0000, 4'b1111, 0, "busyoff_low6_gated");

    // Gate then immediate re-request (idle 0)
    drive(4'b0100, 4'h0, 1, 4'd0, 3'd0);
    run(3, 4'b0100, 4'b0100, 4'b1011, 0, "rereq_wake");
    drive(4'b0000, 4'h0, 1, 4'd0, 3'd0);
    run(1, 4'b0000, 4'b0000, 4'b1111, 0, "rereq_gated");
    drive(4'b0100, 4'h0, 1, 4'd0, 3'd0);
    run(1, 4'b0000, 4'b0000, 4'b1111, 1, "rereq_grant");
    run(1, 4'b0100, 4'b0000, 4'b1011, 1, "rereq_clk_en");
    run(1, 4'b0100, 4'b0100, 4'b1011, 0, "rereq_ack");

    // Global disable with domain 1 WAKING, domains 0/2/3 GATED
    do_reset();
    drive(4'b0010, 4'h0, 1, 4'd2, 3'd5);
    run(2, 4'b0010, 4'b0000, 4'b1101, 1, "dis_waking");
    drive(4'b0010, 4'h0, 0, 4'd2, 3'd5);
    run(1, 4'b1111, 4'b1111, 4'b0000, 0, "dis_forced");
    drive(4'b0000, 4'h0, 0, 4'd2, 3'd5);
    run(3, 4'b1111, 4'b1111, 4'b0000, 0, "dis_hold");
    drive(4'b0000, 4'h0, 1, 4'd2, 3'd5);
    run(2, 4'b1111, 4'b1111, 4'b0000, 0, "reen_counting");
    run(1, 4'b0000, 4'b0000, 4'b1111, 0, "reen_gated");
    // Pointer kept at 2 through the disable: 1001 grants domain 3 first
    drive(4'b1001, 4'h0, 1, 4'd2, 3'd0);
    run(1, 4'b0000, 4'b0000, 4'b1111, 1, "ptr_kept_grant");
    run(1, 4'b1000, 4'b0000, 4'b0111, 1, "ptr_kept_d3");

    // Reset mid-sequence
    do_reset();
    drive(4'b1100, 4'h0, 1, 4'd3, 3'd7);
    run(2, 4'b0100, 4'b0000, 4'b1011, 1, "rstmid_waking");
    run(3, 4'b0100, 4'b0000, 4'b1011, 1, "rstmid_settle");
    #2 aresetn = 1'b0;
    #1 check_now(4'h0, 4'h0, 4'hF, 1'b0, "rstmid_async");
    for (int k = 0; k < 3; k++) begin
      run(1, 4'h0, 4'h0, 4'hF, 0, $sformatf("rstmid_held%0d", k));
    end
    aresetn = 1'b1;
    run(1, 4'b0000, 4'b0000, 4'b1111, 1, "rstmid_regrant");
    run(1, 4'b0100, 4'b0000, 4'b1011, 1, "rstmid_lowest");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
